// File: rtl/wb_pipe_stage_if.sv
// Bundle interface for the MEM/WB elastic stage: upstream handshake, downstream
// handshake, occupancy and forwarding lookup, grouped so the stage takes one port.
interface wb_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
);
  logic                     flush_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [LANES*DATA_W-1:0]  in_wdata_i;
  logic [LANES-1:0]         in_we_i;
  logic [LANES*ADDR_W-1:0]  in_waddr_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [LANES*DATA_W-1:0]  out_wdata_o;
  logic [LANES-1:0]         out_we_o;
  logic [LANES*ADDR_W-1:0]  out_waddr_o;
  logic [1:0]               count_o;
  logic [ADDR_W-1:0]        fwd_raddr_i;
  logic                     fwd_hit_o;
  logic [DATA_W-1:0]        fwd_data_o;

  // Master drives bundles and lookups; slave is the stage itself.
  modport master (
    output flush_i, in_valid_i, in_wdata_i, in_we_i, in_waddr_i, out_ready_i, fwd_raddr_i,
    input  in_ready_o, out_valid_o, out_wdata_o, out_we_o, out_waddr_o, count_o,
           fwd_hit_o, fwd_data_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_wdata_i, in_we_i, in_waddr_i, out_ready_i, fwd_raddr_i,
    output in_ready_o, out_valid_o, out_wdata_o, out_we_o, out_waddr_o, count_o,
           fwd_hit_o, fwd_data_o
  );
endinterface

// File: rtl/wb_pipe_stage.sv
// Elastic MEM/WB stage: two-entry skid buffer of multi-lane register writes with
// flush, x0 write suppression and a combinational forwarding lookup.
module wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
) (
  input  logic            clk,
  input  logic            rst,
  wb_pipe_stage_if.slave  bus
);

  logic [1:0][LANES*DATA_W-1:0] data_q;
  logic [1:0][LANES-1:0]        we_q;
  logic [1:0][LANES*ADDR_W-1:0] addr_q;
  logic                         head_q;
  logic [1:0]                   count_q;

  logic                         accept;
  logic                         drain;
  logic                         wr_idx;
  logic [LANES-1:0]             in_we_masked;
  logic                         fwd_idx;
  logic                         fwd_hit;
  logic [DATA_W-1:0]            fwd_data;

  assign bus.in_ready_o  = (count_q != 2'd2);
  assign bus.out_valid_o = (count_q != 2'd0);
  assign bus.count_o     = count_q;

  assign accept = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
  assign drain  = bus.out_valid_o & bus.out_ready_i & ~bus.flush_i;
  // Accept only happens with count 0 or 1, so (head + count) mod 2 is an XOR.
  assign wr_idx = head_q ^ count_q[0];

  always_comb begin
    in_we_masked = '0;
    for (int l = 0; l < LANES; l++) begin
      in_we_masked[l] = bus.in_we_i[l] & (bus.in_waddr_i[l*ADDR_W +: ADDR_W] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else if (bus.flush_i) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (accept) begin
        data_q[wr_idx] <= bus.in_wdata_i;
        we_q[wr_idx]   <= in_we_masked;
        addr_q[wr_idx] <= bus.in_waddr_i;
      end
      case ({accept, drain})
        2'b10: count_q <= count_q + 2'd1;
        2'b01: begin
          count_q <= count_q - 2'd1;
          head_q  <= ~head_q;
        end
        2'b11: head_q <= ~head_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.out_wdata_o = '0;
    bus.out_we_o    = '0;
    bus.out_waddr_o = '0;
    if (count_q != 2'd0) begin
      bus.out_wdata_o = data_q[head_q];
      bus.out_we_o    = we_q[head_q];
      bus.out_waddr_o = addr_q[head_q];
    end
  end

  // Scan older entry then younger, lanes ascending, so later matches win priority.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_q;
    if (bus.fwd_raddr_i != '0) begin
      for (int e = 0; e < 2; e++) begin
        if (count_q > 2'(e)) begin
          fwd_idx = head_q ^ 1'(e);
          for (int l = 0; l < LANES; l++) begin
            if (we_q[fwd_idx][l] && (addr_q[fwd_idx][l*ADDR_W +: ADDR_W] == bus.fwd_raddr_i)) begin
              fwd_hit  = 1'b1;
              fwd_data = data_q[fwd_idx][l*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

  assign bus.fwd_hit_o  = fwd_hit;
  assign bus.fwd_data_o = fwd_data;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed self-checking bench for wb_pipe_stage with two lanes: reset, streaming,
// backpressure, x0 suppression, flush, forwarding priority and mid-stream reset.
module tb_wb_pipe_stage;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LANES  = 2;

  logic clk;
  logic rst;
  int   tests;
  int   failures;

  wb_pipe_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

  wb_pipe_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [1:0] we, input logic [9:0] addr,
                               input logic [63:0] data, input logic ordy, input logic fl);
    bus.in_valid_i  = valid;
    bus.in_we_i     = we;
    bus.in_waddr_i  = addr;
    bus.in_wdata_i  = data;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst      = 1'b1;
    bus.fwd_raddr_i = '0;
    applyStimulus(1'b0, 2'b00, 10'h0, 64'h0, 1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    checkOutput("reset_count", 64'(bus.count_o), 64'd0);
    checkOutput("reset_in_ready", 64'(bus.in_ready_o), 64'd1);
    checkOutput("reset_out_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("reset_out_wdata", bus.out_wdata_o, 64'd0);
    checkOutput("reset_fwd_hit", 64'(bus.fwd_hit_o), 64'd0);
    rst = 1'b0;

    // Streaming: bundle n appears one cycle after it is offered, no gaps
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n > 1) begin
        checkOutput("stream_valid", 64'(bus.out_valid_o), 64'd1);
        checkOutput("stream_addr", 64'(bus.out_waddr_o), 64'(n - 1));
        checkOutput("stream_data", bus.out_wdata_o, 64'(32'h100 + n - 1));
        checkOutput("stream_we", 64'(bus.out_we_o), 64'b01);
        checkOutput("stream_count", 64'(bus.count_o), 64'd1);
      end
      if (n <= 8) applyStimulus(1'b1, 2'b01, 10'(n), 64'(32'h100 + n), 1'b1, 1'b0);
      else        applyStimulus(1'b0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
    end
    @(negedge clk);
    checkOutput("stream_empty", 64'(bus.count_o), 64'd0);

    // Backpressure: A, B accepted; C held upstream
    applyStimulus(1'b1, 2'b01, 10'd10, 64'hA, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_count1", 64'(bus.count_o), 64'd1);
    checkOutput("bp_ready1", 64'(bus.in_ready_o), 64'd1);
    applyStimulus(1'b1, 2'b01, 10'd11, 64'hB, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_count2", 64'(bus.count_o), 64'd2);
    checkOutput("bp_ready2", 64'(bus.in_ready_o), 64'd0);
    checkOutput("bp_head_a", 64'(bus.out_waddr_o), 64'd10);
    applyStimulus(1'b1, 2'b01, 10'd12, 64'hC, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_hold_count", 64'(bus.count_o), 64'd2);
    checkOutput("bp_hold_head", bus.out_wdata_o, 64'hA);
    applyStimulus(1'b1, 2'b01, 10'd12, 64'hC, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_out_b", bus.out_wdata_o, 64'hB);
    checkOutput("bp_count_after_a", 64'(bus.count_o), 64'd1);
    checkOutput("bp_ready_after_a", 64'(bus.in_ready_o), 64'd1);
    @(negedge clk);
    checkOutput("bp_out_c", bus.out_wdata_o, 64'hC);
    checkOutput("bp_count_c", 64'(bus.count_o), 64'd1);
    applyStimulus(1'b0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_drained", 64'(bus.count_o), 64'd0);

    // x0 suppression: lane0 writes x0, lane1 writes x3
    applyStimulus(1'b1, 2'b11, {5'd3, 5'd0}, {32'h33, 32'hDEAD}, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("x0_we", 64'(bus.out_we_o), 64'b10);
    checkOutput("x0_addr", 64'(bus.out_waddr_o), 64'h060);
    checkOutput("x0_data", bus.out_wdata_o, 64'h00000033_0000DEAD);
    bus.fwd_raddr_i = 5'd0;
    #1;
    checkOutput("x0_fwd_hit", 64'(bus.fwd_hit_o), 64'd0);
    checkOutput("x0_fwd_data", 64'(bus.fwd_data_o), 64'd0);
    bus.fwd_raddr_i = 5'd3;
    #1;
    checkOutput("x3_fwd_hit", 64'(bus.fwd_hit_o), 64'd1);
    checkOutput("x3_fwd_data", 64'(bus.fwd_data_o), 64'h33);

    // Flush with count 2, alongside an offered bundle and a drain
    applyStimulus(1'b1, 2'b01, {5'd0, 5'd7}, 64'h77, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fl_count2", 64'(bus.count_o), 64'd2);
    applyStimulus(1'b1, 2'b01, {5'd0, 5'd9}, 64'h99, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("fl_count", 64'(bus.count_o), 64'd0);
    checkOutput("fl_out_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("fl_out_we", 64'(bus.out_we_o), 64'd0);
    checkOutput("fl_fwd_hit", 64'(bus.fwd_hit_o), 64'd0);
    applyStimulus(1'b0, 2'b00, 10'h0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fl_lost", 64'(bus.count_o), 64'd0);

    // Forwarding priority: younger lane1 beats younger lane0 beats older
    applyStimulus(1'b1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h11}, 1'b0, 1'b0);
    @(negedge clk);
    bus.fwd_raddr_i = 5'd5;
    #1;
    checkOutput("fwd_old_hit", 64'(bus.fwd_hit_o), 64'd1);
    checkOutput("fwd_old_data", 64'(bus.fwd_data_o), 64'h11);
    applyStimulus(1'b1, 2'b11, {5'd5, 5'd5}, {32'h33, 32'h22}, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fwd_young_hit", 64'(bus.fwd_hit_o), 64'd1);
    checkOutput("fwd_young_data", 64'(bus.fwd_data_o), 64'h33);
    applyStimulus(1'b0, 2'b00, 10'h0, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fwd_flushed_hit", 64'(bus.fwd_hit_o), 64'd0);
    checkOutput("fwd_flushed_data", 64'(bus.fwd_data_o), 64'd0);

    // Asynchronous reset with the buffer full
    applyStimulus(1'b1, 2'b01, {5'd0, 5'd4}, 64'h44, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ar_full", 64'(bus.count_o), 64'd2);
    applyStimulus(1'b0, 2'b00, 10'h0, 64'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("ar_out_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("ar_out_wdata", bus.out_wdata_o, 64'd0);
    checkOutput("ar_count", 64'(bus.count_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ar_ready", 64'(bus.in_ready_o), 64'd1);
    checkOutput("ar_count_after", 64'(bus.count_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Parametrised MEM/WB pipeline stage for the next-generation core. It replaces the fixed single-lane, always-advancing MEM/WB register with an elastic stage that:
- carries `LANES` register-write lanes per bundle;
- holds up to two bundles in a skid buffer under valid/ready backpressure;
- supports flush;
- suppresses writes to x0;
- provides a combinational forwarding lookup over the bundles it holds.

It sits between the MEM stage and the register-file write port.

## Interface
- `DATA_W`, default 32, register data width
- `ADDR_W`, default 5, register address width
- `LANES`, default 1, write lanes per bundle (1..4)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush_i`  in  1  discard all held bundles and any bundle offered this cycle
- `in_valid_i`  in  1  upstream bundle valid
- `in_ready_o`  out  1  stage can accept a bundle
- `in_wdata_i`  in  `LANES*DATA_W`  write data; lane i occupies `[i*DATA_W +: DATA_W]`
- `in_we_i`  in  `LANES`  per-lane write enable
- `in_waddr_i`  in  `LANES*ADDR_W`  per-lane write address
- `out_valid_o`  out  1  head bundle valid
- `out_ready_i`  in  1  downstream consumes the head bundle
- `out_wdata_o`  out  `LANES*DATA_W`  head bundle data
- `out_we_o`  out  `LANES`  head bundle enables, x0-masked
- `out_waddr_o`  out  `LANES*ADDR_W`  head bundle addresses
- `count_o`  out  2  number of held bundles (0..2)
- `fwd_raddr_i`  in  `ADDR_W`  forwarding lookup address
- `fwd_hit_o`  out  1  a held bundle writes `fwd_raddr_i`
- `fwd_data_o`  out  `DATA_W`  data of the matching write; 0 when no hit

## Operation
**Storage**
- Two bundle entries, a head pointer and a 2-bit count.
- Each entry stores `LANES` × {data, we, addr}.

**Handshake**
- Accept = `in_valid_i & in_ready_o & ~flush_i`.
- Drain = `out_valid_o & out_ready_i & ~flush_i`.
- `in_ready_o` = (count != 2). It is combinational from registered state and never depends on `in_valid_i`.
- `out_valid_o` = (count != 0).

**Capture**
- An accepted bundle is written to entry (head + count) mod 2.
- Stored we[i] = `in_we_i[i]` & (`in_waddr_i` lane i != 0). A write to x0 is therefore never emitted.
- Data and address are stored unmodified.

**Count update**
- Accept only: +1. Drain only: −1 and head toggles. Both in the same cycle: count unchanged, head toggles.
- Accept and drain at count 2 cannot occur, because ready is low.

**Output**
- Outputs reflect the head entry when count ≥ 1.
- When count = 0, `out_wdata_o`, `out_we_o` and `out_waddr_o` are all 0.

**Flush**
- On the next edge, count → 0 and head → 0.
- Flush has priority over accept and drain in the same cycle. Neither takes effect.

**Forwarding lookup (combinational)**
- Search only valid held entries, never the input bundle.
- A lane matches when its stored we = 1 and addr == `fwd_raddr_i`.
- Priority: younger entry before older; within an entry, higher lane index first.
- When `fwd_raddr_i` = 0: hit = 0 and data = 0.

**Reset**
- count 0, head 0, all entry storage 0.
- Resulting outputs: `out_valid_o` = 0, `out_*` = 0, `count_o` = 0, `in_ready_o` = 1, `fwd_hit_o` = 0, `fwd_data_o` = 0.
- Handshakes are ignored while `rst` is high.
- Reset asserted mid-stream drops all held bundles immediately, asynchronously.

## Timing
- Latency is 1 cycle. A bundle accepted at edge k appears on `out_*` with `out_valid_o` = 1 in the cycle after edge k.
- Throughput is 1 bundle/cycle with `out_ready_i` held high; count stays ≤ 1.
- Two stalled cycles with input valid fill the buffer. `in_ready_o` falls in the cycle after the second accept.
- No combinational path from `out_ready_i` or `in_valid_i` to `in_ready_o`.
- Forwarding outputs settle within the same cycle as a `fwd_raddr_i` change.
- All state changes occur on rising `clk`, except reset.

## Test plan
- **Reset:** assert `rst` mid-cycle with count = 2 → outputs zero immediately; `in_ready_o` = 1 and `count_o` = 0 after release.
- **Streaming** (`LANES` = 1, `out_ready_i` = 1): 8 bundles, addr 1..8, data `0x100+n`, one per cycle → identical sequence on output, one cycle later, no gaps.
- **Backpressure:** `out_ready_i` = 0 for 3 cycles while offering A, B, C → A and B accepted, C held upstream with `in_ready_o` = 0, `count_o` = 2. Then `out_ready_i` = 1 → output A, B, C in order.
- **x0 suppression:** lane0 we = 1 addr 0 data `0xDEAD`; lane1 we = 1 addr 3 → `out_we_o` = `2'b10`; `fwd_raddr_i` = 0 gives hit = 0.
- **Flush:** count = 2, assert `flush_i` together with `in_valid_i` and `out_ready_i` → next cycle count = 0, `out_valid_o` = 0, offered bundle lost.
- **Forwarding** (`LANES` = 2): older entry writes x5 = `0x11`; younger entry has lane0 x5 = `0x22` and lane1 x5 = `0x33` → `fwd_data_o` = `0x33`. After the younger entry is flushed, the lookup gives hit = 0.
